id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage of the MIPS core. Captures operands read from the register file plus
//  decoded control, and bypasses same-cycle WB writes, which the register file does not forward.
//  Forwards MEM/WB results into the EX operands and detects load-use hazards.
//  Generates the stall to IF/ID. Sits between decode/register file and the ALU.
// PARAMETERS
//  DATA_W     32  operand/result width
//  REGADDR_W  5   register index width (32 registers, r0 hardwired zero)
// PORTS
//  clk           in   1          clock, all state on posedge
//  resetN        in   1          asynchronous, active-low reset
//  id_valid      in   1          ID holds a real instruction
//  id_rs, id_rt  in   REGADDR_W  source register indices (also drive register file rdReg1/rdReg2)
//  id_usesRt     in   1          instruction reads rt (R-type, store, beq/bne)
//  id_dest       in   REGADDR_W  destination index after RegDst mux
//  id_rfData1/2  in   DATA_W     register file data1/data2
//  id_imm        in   DATA_W     sign/zero-extended immediate
//  id_ctrl       in   ctrl_t     regWrite, memRead, memWrite, memToReg, aluSrc, aluOp[3:0]
//  flush         in   1          squash the ID instruction (taken branch/jump)
//  hold          in   1          global freeze (memory wait); MEM/WB also frozen
//  mem_regWrite  in   1          EX/MEM instruction writes a register
//  mem_dest      in   REGADDR_W  its destination
//  mem_result    in   DATA_W     its ALU result
//  wb_regWrite   in   1          MEM/WB writes (same signals as register file regWrite/wrReg/wrData)
//  wb_dest       in   REGADDR_W
//  wb_data       in   DATA_W
//  stall         out  1          IF/ID must hold this cycle
//  ex_valid      out  1          EX holds a real instruction
//  ex_opA/ex_opB out  DATA_W     forwarded operands (opB = rt value, before aluSrc mux)
//  ex_imm        out  DATA_W     registered immediate
//  ex_dest       out  REGADDR_W  registered destination
//  ex_ctrl       out  ctrl_t     registered control; all-zero when bubble
// BEHAVIOUR
//  - Reset: ex_valid=0, ex_ctrl='0, ex_dest=0, ex_imm=0, latched rs/rt/operands=0,
//    flushPend=0; so ex_opA=ex_opB=0 and stall=0 out of reset.
//  - ID bypass: capA = (wb_regWrite && wb_dest==id_rs && id_rs!=0) ? wb_data : id_rfData1; capB same with rt.
//  - loadUse = id_valid && ex_valid && ex_ctrl.memRead && ex_dest!=0 &&
//    (ex_dest==id_rs || (id_usesRt && ex_dest==id_rt)).
//  - stall = hold | (loadUse & ~flush & ~flushPend); combinational, same cycle.
//  - Register update per posedge, priority order:
//    1 hold: all EX registers keep value; if flush=1, set flushPend=1.
//    2 flush|flushPend: bubble (ex_valid=0, ex_ctrl='0), clear flushPend.
//    3 loadUse: bubble. The ID instruction re-enters next cycle and re-reads the register file.
//    4 else: capture id_* with capA/capB; ex_valid=id_valid, ex_ctrl=id_valid?id_ctrl:'0.
//  - Latency: one cycle ID->EX; load-use costs exactly one bubble.
//  - EX forwarding, combinational from the latched rs/rt:
//    opA = (mem_regWrite && mem_dest==ex_rs && ex_rs!=0) ? mem_result
//        : (wb_regWrite && wb_dest==ex_rs && ex_rs!=0) ? wb_data : latchedA
//    opB is identical, using ex_rt. MEM beats WB when both match. r0 is never forwarded.
//  - Under hold, forwarding still evaluates; sources are frozen, so outputs stay stable.
//  - Reset deasserted mid-operation: EX restarts as a bubble and flushPend is lost (upstream is reset too).
//  - No arithmetic. Equality compares use the full REGADDR_W width.
// STRUCTURE
//  - mips_pkg: ctrl_t packed struct; DATA_W/REGADDR_W defaults; REG_ZERO=5'd0; CTRL_BUBBLE='0.
//  - Sub-module fwd_mux: one instance per operand (inputs: index, latched value, mem/wb triples).
//    The ID bypass reuses the same compare in a one-source form.
//  - Hazard logic and pipeline register stay in this module.
// TESTING
//  1 Reset low mid-run with ex_valid=1 -> ex_valid=0, ex_ctrl=0, ex_opA=ex_opB=0, stall=0 at once.
//  2 EX rs=r3 latched 5; mem writes r3=0x10 and wb writes r3=0x20 -> opA=0x10. Drop mem -> 0x20.
//  3 Instruction rs=r0; mem_dest=0 with regWrite and result 0xFFFF -> opA keeps latched 0.
//  4 lw r4 in EX; ID add rs=r4 -> stall=1 one cycle, then bubble. Next cycle: stall=0 and add enters.
//    Same with id_usesRt=0 and rt=r4 -> no stall.
//  5 WB writes r7=0xABCD while ID reads r7 (rf returns old 0x1) -> ex_opA=0xABCD after capture.
//  6 hold=1 for 3 cycles with flush pulsed in cycle 1 -> EX frozen and stall=1.
//    First cycle after hold: bubble. Also flush with loadUse together -> bubble, stall=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS pipeline.
// Control bundle carried from decode into EX.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REGADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic [3:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: MEM result beats WB data.
// r0 is never forwarded, it always reads as its latched value.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REGADDR_W
) (
  input  logic [AW-1:0] idx_i,
  input  logic [DW-1:0] lat_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_dest_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_dest_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] val_o
);

  // Pick the youngest in-flight producer of idx_i.
  always_comb begin
    val_o = lat_i;
    if (idx_i != '0) begin
      if (mem_we_i && mem_dest_i == idx_i) begin
        val_o = mem_data_i;
      end else if (wb_we_i && wb_dest_i == idx_i) begin
        val_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, EX forwarding
// and load-use stall generation.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int REGADDR_W = mips_pkg::REGADDR_W
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 id_valid,
  input  logic [REGADDR_W-1:0] id_rs,
  input  logic [REGADDR_W-1:0] id_rt,
  input  logic                 id_usesRt,
  input  logic [REGADDR_W-1:0] id_dest,
  input  logic [DATA_W-1:0]    id_rfData1,
  input  logic [DATA_W-1:0]    id_rfData2,
  input  logic [DATA_W-1:0]    id_imm,
  input  ctrl_t                id_ctrl,
  input  logic                 flush,
  input  logic                 hold,
  input  logic                 mem_regWrite,
  input  logic [REGADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]    mem_result,
  input  logic                 wb_regWrite,
  input  logic [REGADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_opA,
  output logic [DATA_W-1:0]    ex_opB,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [REGADDR_W-1:0] ex_dest,
  output ctrl_t                ex_ctrl
);

  logic                 ex_valid_q, ex_valid_d;
  ctrl_t                ex_ctrl_q, ex_ctrl_d;
  logic [REGADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic [REGADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REGADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [DATA_W-1:0]    ex_imm_q, ex_imm_d;
  logic [DATA_W-1:0]    ex_a_q, ex_a_d;
  logic [DATA_W-1:0]    ex_b_q, ex_b_d;
  logic                 fpend_q, fpend_d;

  logic [DATA_W-1:0]    cap_a, cap_b;
  logic                 load_use;
  logic                 hit_rs, hit_rt;

  // The register file does not bypass its own write port.
  fwd_mux #(.DW(DATA_W), .AW(REGADDR_W)) u_byp_a (
    .idx_i(id_rs), .lat_i(id_rfData1),
    .mem_we_i(1'b0), .mem_dest_i('0), .mem_data_i('0),
    .wb_we_i(wb_regWrite), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .val_o(cap_a)
  );

  fwd_mux #(.DW(DATA_W), .AW(REGADDR_W)) u_byp_b (
    .idx_i(id_rt), .lat_i(id_rfData2),
    .mem_we_i(1'b0), .mem_dest_i('0), .mem_data_i('0),
    .wb_we_i(wb_regWrite), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .val_o(cap_b)
  );

  fwd_mux #(.DW(DATA_W), .AW(REGADDR_W)) u_fwd_a (
    .idx_i(ex_rs_q), .lat_i(ex_a_q),
    .mem_we_i(mem_regWrite), .mem_dest_i(mem_dest),
    .mem_data_i(mem_result),
    .wb_we_i(wb_regWrite), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .val_o(ex_opA)
  );

  fwd_mux #(.DW(DATA_W), .AW(REGADDR_W)) u_fwd_b (
    .idx_i(ex_rt_q), .lat_i(ex_b_q),
    .mem_we_i(mem_regWrite), .mem_dest_i(mem_dest),
    .mem_data_i(mem_result),
    .wb_we_i(wb_regWrite), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .val_o(ex_opB)
  );

  // Load in EX whose result the ID instruction needs.
  always_comb begin
    hit_rs   = ex_dest_q == id_rs;
    hit_rt   = id_usesRt && ex_dest_q == id_rt;
    load_use = id_valid && ex_valid_q
            && ex_ctrl_q.memRead
            && ex_dest_q != REGADDR_W'(REG_ZERO)
            && (hit_rs || hit_rt);
    stall    = hold | (load_use & ~flush & ~fpend_q);
  end

  // Next EX contents: hold > flush > load-use > capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_dest_d  = ex_dest_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_imm_d   = ex_imm_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    fpend_d    = fpend_q;
    if (hold) begin
      fpend_d = fpend_q | flush;
    end else if (flush || fpend_q) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = CTRL_BUBBLE;
      fpend_d    = 1'b0;
    end else if (load_use) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = CTRL_BUBBLE;
    end else begin
      ex_valid_d = id_valid;
      ex_ctrl_d  = id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_dest_d  = id_dest;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_imm_d   = id_imm;
      ex_a_d     = cap_a;
      ex_b_d     = cap_b;
    end
  end

  // Pipeline register; reset leaves a bubble.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_dest_q  <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_imm_q   <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      fpend_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dest_q  <= ex_dest_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_imm_q   <= ex_imm_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      fpend_q    <= fpend_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_dest  = ex_dest_q;
  assign ex_imm   = ex_imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: forwarding table,
// hazard/hold/reset sequences and a randomized model run.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        id_valid, id_usesRt, flush, hold;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_rfData1, id_rfData2, id_imm;
  ctrl_t       id_ctrl;
  logic        mem_regWrite, wb_regWrite;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_opA, ex_opB, ex_imm;
  logic [4:0]  ex_dest;
  ctrl_t       ex_ctrl;

  id_ex_stage dut (
    .clk(clk), .resetN(resetN),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_usesRt(id_usesRt), .id_dest(id_dest),
    .id_rfData1(id_rfData1), .id_rfData2(id_rfData2),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .hold(hold),
    .mem_regWrite(mem_regWrite), .mem_dest(mem_dest),
    .mem_result(mem_result),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest),
    .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference EX contents, tracked from the stage rules.
  logic        m_valid, m_fp;
  ctrl_t       m_ctrl;
  logic [4:0]  m_dest, m_rs, m_rt;
  logic [31:0] m_imm, m_a, m_b;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(logic [4:0] r,
                                          logic [31:0] lat);
    if (r == 5'd0) return lat;
    if (mem_regWrite && mem_dest == r) return mem_result;
    if (wb_regWrite && wb_dest == r) return wb_data;
    return lat;
  endfunction

  function automatic logic [31:0] ref_byp(logic [4:0] r,
                                          logic [31:0] rf);
    if (r != 5'd0 && wb_regWrite && wb_dest == r)
      return wb_data;
    return rf;
  endfunction

  function automatic logic ref_lu();
    logic needs;
    needs = (m_dest == id_rs) ||
            (id_usesRt && m_dest == id_rt);
    return id_valid && m_valid && m_ctrl.memRead &&
           m_dest != 5'd0 && needs;
  endfunction

  function automatic logic ref_stall();
    return hold || (ref_lu() && !flush && !m_fp);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_fp = 0; m_ctrl = '0;
    m_dest = 0; m_rs = 0; m_rt = 0;
    m_imm = 0; m_a = 0; m_b = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_usesRt = 0; flush = 0; hold = 0;
    id_rs = 0; id_rt = 0; id_dest = 0;
    id_rfData1 = 0; id_rfData2 = 0; id_imm = 0;
    id_ctrl = '0;
    mem_regWrite = 0; mem_dest = 0; mem_result = 0;
    wb_regWrite = 0; wb_dest = 0; wb_data = 0;
  endtask

  // One clock: advance the reference with the applied inputs.
  task automatic tick();
    logic lu;
    @(posedge clk);
    lu = ref_lu();
    if (hold) begin
      m_fp = m_fp | flush;
    end else if (flush || m_fp) begin
      m_valid = 0; m_ctrl = '0; m_fp = 0;
    end else if (lu) begin
      m_valid = 0; m_ctrl = '0;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? id_ctrl : '0;
      m_dest  = id_dest;
      m_rs    = id_rs;
      m_rt    = id_rt;
      m_imm   = id_imm;
      m_a     = ref_byp(id_rs, id_rfData1);
      m_b     = ref_byp(id_rt, id_rfData2);
    end
    #1;
  endtask

  task automatic put_load(logic [4:0] d);
    idle();
    id_valid = 1; id_dest = d; id_rs = 5'd1;
    id_ctrl.regWrite = 1; id_ctrl.memRead = 1;
    tick();
  endtask

  typedef struct {
    logic [4:0]  rs;
    logic [31:0] lat;
    logic        mwe;
    logic [4:0]  md;
    logic [31:0] mr;
    logic        wwe;
    logic [4:0]  wd;
    logic [31:0] wdat;
    logic [31:0] expA;
    logic [31:0] expB;
  } fv_t;

  fv_t tbl[7];

  initial begin
    tbl[0] = '{5'd3, 32'h5, 1, 5'd3, 32'h10, 1, 5'd3,
               32'h20, 32'h10, 32'h10};
    tbl[1] = '{5'd3, 32'h5, 0, 5'd3, 32'h10, 1, 5'd3,
               32'h20, 32'h20, 32'h20};
    tbl[2] = '{5'd0, 32'h0, 1, 5'd0, 32'hFFFF, 1, 5'd0,
               32'h1234, 32'h0, 32'hFFFF_FFFF};
    tbl[3] = '{5'd3, 32'h5, 1, 5'd4, 32'h10, 1, 5'd3,
               32'h20, 32'h20, 32'h20};
    tbl[4] = '{5'd3, 32'h5, 1, 5'd4, 32'h10, 1, 5'd5,
               32'h20, 32'h5, 32'hFFFF_FFFA};
    tbl[5] = '{5'd31, 32'h77, 0, 5'd31, 32'h1, 0, 5'd31,
               32'h2, 32'h77, 32'hFFFF_FF88};
    tbl[6] = '{5'd2, 32'h9, 1, 5'd2, 32'hAA, 1, 5'd1,
               32'hBB, 32'hAA, 32'hAA};

    idle();
    model_reset();
    resetN = 0;
    #12;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_opA", ex_opA, 32'd0);
    chk("rst_opB", ex_opB, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    resetN = 1;
    #10;

    // Forwarding table: capture, then present MEM/WB.
    for (int i = 0; i < 7; i++) begin
      idle();
      id_valid = 1;
      id_rs = tbl[i].rs; id_rt = tbl[i].rs;
      id_rfData1 = tbl[i].lat;
      id_rfData2 = ~tbl[i].lat;
      tick();
      idle();
      mem_regWrite = tbl[i].mwe; mem_dest = tbl[i].md;
      mem_result = tbl[i].mr;
      wb_regWrite = tbl[i].wwe; wb_dest = tbl[i].wd;
      wb_data = tbl[i].wdat;
      #1;
      chk($sformatf("fwdA[%0d]", i), ex_opA, tbl[i].expA);
      chk($sformatf("fwdB[%0d]", i), ex_opB, tbl[i].expB);
    end

    // Load-use on rs: one bubble, then the add enters.
    put_load(5'd4);
    id_valid = 1; id_ctrl = '0;
    id_ctrl.regWrite = 1; id_ctrl.aluOp = 4'h2;
    id_rs = 5'd4; id_rt = 5'd5; id_usesRt = 1;
    id_dest = 5'd6;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
    chk("lu_stall_off", 32'(stall), 32'd0);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_ctrl", 32'(ex_ctrl), 32'h102);
    chk("lu_add_dest", 32'(ex_dest), 32'd6);

    // rt match ignored when rt is not read.
    put_load(5'd4);
    id_valid = 1; id_rs = 5'd5; id_rt = 5'd4;
    id_usesRt = 0; id_dest = 5'd7;
    #1;
    chk("nort_stall", 32'(stall), 32'd0);
    id_usesRt = 1;
    #1;
    chk("rt_stall", 32'(stall), 32'd1);
    id_usesRt = 0;
    tick();
    chk("nort_valid", 32'(ex_valid), 32'd1);

    // Asynchronous reset mid-run.
    mem_regWrite = 1; mem_dest = 0; mem_result = 32'hFFFF;
    #2;
    resetN = 0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("arst_opA", ex_opA, 32'd0);
    chk("arst_opB", ex_opB, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    model_reset();
    idle();
    #3;
    resetN = 1;
    #10;

    // Same-cycle WB write bypassed into the capture.
    idle();
    id_valid = 1; id_rs = 5'd7; id_rt = 5'd7;
    id_rfData1 = 32'h1; id_rfData2 = 32'h1;
    wb_regWrite = 1; wb_dest = 5'd7; wb_data = 32'hABCD;
    tick();
    wb_regWrite = 0; id_valid = 0;
    #1;
    chk("byp_opA", ex_opA, 32'hABCD);
    chk("byp_opB", ex_opB, 32'hABCD);

    // Hold for three cycles with a flush in the first.
    idle();
    id_valid = 1; id_dest = 5'd9; id_imm = 32'h55;
    id_ctrl.aluOp = 4'h3;
    tick();
    hold = 1; flush = 1; id_dest = 5'd10; id_imm = 32'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold_stall[%0d]", c), 32'(stall), 32'd1);
      tick();
      flush = 0;
      chk($sformatf("hold_valid[%0d]", c),
          32'(ex_valid), 32'd1);
      chk($sformatf("hold_dest[%0d]", c), 32'(ex_dest), 32'd9);
      chk($sformatf("hold_imm[%0d]", c), ex_imm, 32'h55);
    end
    hold = 0;
    #1;
    chk("unhold_stall", 32'(stall), 32'd0);
    tick();
    chk("pend_bub_valid", 32'(ex_valid), 32'd0);
    chk("pend_bub_ctrl", 32'(ex_ctrl), 32'd0);
    tick();
    chk("after_pend_valid", 32'(ex_valid), 32'd1);
    chk("after_pend_dest", 32'(ex_dest), 32'd10);

    // Flush together with load-use: bubble, no stall.
    put_load(5'd4);
    id_valid = 1; id_rs = 5'd4; flush = 1;
    #1;
    chk("fl_lu_stall", 32'(stall), 32'd0);
    tick();
    chk("fl_lu_valid", 32'(ex_valid), 32'd0);
    idle();

    // Randomized run against the reference.
    for (int n = 0; n < 400; n++) begin
      id_valid   = 1'($urandom_range(0, 3) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_usesRt  = 1'($urandom);
      id_dest    = 5'($urandom_range(0, 3));
      id_rfData1 = $urandom;
      id_rfData2 = $urandom;
      id_imm     = $urandom;
      id_ctrl    = ctrl_t'($urandom);
      flush      = 1'($urandom_range(0, 7) == 0);
      hold       = 1'($urandom_range(0, 7) == 0);
      mem_regWrite = 1'($urandom);
      mem_dest   = 5'($urandom_range(0, 3));
      mem_result = $urandom;
      wb_regWrite = 1'($urandom);
      wb_dest    = 5'($urandom_range(0, 3));
      wb_data    = $urandom;
      #1;
      chk("rnd_stall", 32'(stall), 32'(ref_stall()));
      chk("rnd_opA", ex_opA, ref_fwd(m_rs, m_a));
      chk("rnd_opB", ex_opB, ref_fwd(m_rt, m_b));
      tick();
      chk("rnd_valid", 32'(ex_valid), 32'(m_valid));
      chk("rnd_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      chk("rnd_dest", 32'(ex_dest), 32'(m_dest));
      chk("rnd_imm", ex_imm, m_imm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
